// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: instruction layout,
// selector codes, FSM state codes and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_MOV = 2'b00,
    TYPE_ALU = 2'b01,
    TYPE_IN  = 2'b10,
    TYPE_NOP = 2'b11
  } instr_type_e;

  localparam logic [2:0] SEL_G0      = 3'd0;
  localparam logic [2:0] SEL_G1      = 3'd1;
  localparam logic [2:0] SEL_G2      = 3'd2;
  localparam logic [2:0] SEL_G3      = 3'd3;
  localparam logic [2:0] SEL_P0      = 3'd4;
  localparam logic [2:0] SEL_P1      = 3'd5;
  localparam logic [2:0] SEL_PC      = 3'd6;
  localparam logic [2:0] SEL_ILLEGAL = 3'd7;

  // Bus targets reachable as a source (G0..G3, P0, P1, PC) and as a destination (G0..G3, P0)
  localparam int unsigned SRC_TARGETS = 7;
  localparam int unsigned DST_TARGETS = 5;

  localparam int TYPE_LSB = 14;
  localparam int OP_LSB   = 11;
  localparam int DST_LSB  = 8;
  localparam int SRCA_LSB = 5;
  localparam int SRCB_LSB = 2;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_MOV    = 4'd1;
  localparam state_t ST_ALU_A  = 4'd2;
  localparam state_t ST_ALU_B  = 4'd3;
  localparam state_t ST_ALU_EX = 4'd4;
  localparam state_t ST_ALU_WB = 4'd5;
  localparam state_t ST_IN     = 4'd6;
  localparam state_t ST_NOP    = 4'd7;
  localparam state_t ST_ERR    = 4'd8;
  localparam state_t ST_HALT   = 4'd9;

  typedef struct packed {
    instr_type_e typ;
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
  } fields_t;

  function automatic fields_t split_instr(logic [15:0] w);
    fields_t f;
    f.typ   = instr_type_e'(w[TYPE_LSB +: 2]);
    f.op    = w[OP_LSB   +: 3];
    f.dst   = w[DST_LSB  +: 3];
    f.src_a = w[SRCA_LSB +: 3];
    f.src_b = w[SRCB_LSB +: 3];
    return f;
  endfunction

  function automatic logic src_ok(logic [2:0] sel);
    return sel != SEL_ILLEGAL;
  endfunction

  function automatic logic dst_ok(logic [2:0] sel);
    return sel <= SEL_P0;
  endfunction

  // Only the fields a type actually uses are checked for legality
  function automatic state_t entry_state(logic [15:0] w);
    fields_t f;
    state_t  s;
    f = split_instr(w);
    case (f.typ)
      TYPE_MOV: s = (dst_ok(f.dst) && src_ok(f.src_a)) ? ST_MOV : ST_ERR;
      TYPE_ALU: s = (dst_ok(f.dst) && src_ok(f.src_a) && src_ok(f.src_b))
                    ? ST_ALU_A : ST_ERR;
      TYPE_IN:  s = ST_IN;
      default:  s = ST_NOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction handshake plus every datapath control strobe driven by the sequencer.
interface mc_control_unit_if;

  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        done;
  logic        err;
  logic [2:0]  opCode;
  logic        ALUin1;
  logic        ALUin2;
  logic        ALU_outlach;
  logic        ALU_outEN;
  logic        G0_in, G1_in, G2_in, G3_in;
  logic        G0_out, G1_out, G2_out, G3_out;
  logic        PC_EN;
  logic        P0_in, P0_out, P1_in, P1_out;

  modport slave (
    input  instr, instr_valid,
    output instr_ready, done, err, opCode,
           ALUin1, ALUin2, ALU_outlach, ALU_outEN,
           G0_in, G1_in, G2_in, G3_in,
           G0_out, G1_out, G2_out, G3_out,
           PC_EN, P0_in, P0_out, P1_in, P1_out
  );

  modport master (
    output instr, instr_valid,
    input  instr_ready, done, err, opCode,
           ALUin1, ALUin2, ALU_outlach, ALU_outEN,
           G0_in, G1_in, G2_in, G3_in,
           G0_out, G1_out, G2_out, G3_out,
           PC_EN, P0_in, P0_out, P1_in, P1_out
  );

endinterface

// File: rtl/mc_sel_decode.sv
// Combinational selector decode: 3-bit bus target code to a one-hot enable vector.
// Codes at or beyond N_TARGETS light nothing, so an illegal code can never drive or load.
module mc_sel_decode #(
  parameter int unsigned N_TARGETS = 7
) (
  input  logic [2:0]           i_sel,
  input  logic                 i_en,
  output logic [N_TARGETS-1:0] o_vec
);

  always_comb begin
    for (int k = 0; k < N_TARGETS; k++) begin
      o_vec[k] = i_en && (i_sel == 3'(k));
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle instruction sequencer: latches one instruction word from IDLE and
// steps the datapath strobes through MOV / ALU / IN / NOP / ERR sequences.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_unit_if.slave   cu
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  fields_t     w_f;

  logic [2:0]             w_src_sel;
  logic                   w_src_en;
  logic                   w_dst_en;
  logic [SRC_TARGETS-1:0] w_src_vec;
  logic [DST_TARGETS-1:0] w_dst_vec;

  assign w_f = split_instr(r_ir);

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && cu.instr_valid) begin
        r_ir <= cu.instr;
      end
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (cu.instr_valid) w_state_nxt = entry_state(cu.instr);
      ST_MOV:    w_state_nxt = ST_IDLE;
      ST_ALU_A:  w_state_nxt = ST_ALU_B;
      ST_ALU_B:  w_state_nxt = ST_ALU_EX;
      ST_ALU_EX: w_state_nxt = ST_ALU_WB;
      ST_ALU_WB: w_state_nxt = ST_IDLE;
      ST_IN:     w_state_nxt = ST_IDLE;
      ST_NOP:    w_state_nxt = ST_IDLE;
      ST_ERR:    w_state_nxt = HALT_ON_ERR ? ST_HALT : ST_IDLE;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // One source decoder serves both operand reads; srcB is only selected in ALU_B
  assign w_src_sel = (r_state == ST_ALU_B) ? w_f.src_b : w_f.src_a;
  assign w_src_en  = (r_state == ST_MOV) || (r_state == ST_ALU_A) || (r_state == ST_ALU_B);
  assign w_dst_en  = (r_state == ST_MOV) || (r_state == ST_ALU_WB);

  mc_sel_decode #(.N_TARGETS(SRC_TARGETS)) u_src_decode (
    .i_sel (w_src_sel),
    .i_en  (w_src_en),
    .o_vec (w_src_vec)
  );

  mc_sel_decode #(.N_TARGETS(DST_TARGETS)) u_dst_decode (
    .i_sel (w_f.dst),
    .i_en  (w_dst_en),
    .o_vec (w_dst_vec)
  );

  // Every output is a decode of state and IR only; reset reaches them through r_state
  assign cu.instr_ready = (r_state == ST_IDLE);
  assign cu.done        = (r_state == ST_MOV)    || (r_state == ST_ALU_WB) ||
                          (r_state == ST_IN)     || (r_state == ST_NOP)    ||
                          (r_state == ST_ERR);
  assign cu.err         = (r_state == ST_ERR);
  assign cu.opCode      = (r_state == ST_ALU_EX) ? w_f.op : 3'b000;
  assign cu.ALUin1      = (r_state == ST_ALU_A);
  assign cu.ALUin2      = (r_state == ST_ALU_B);
  assign cu.ALU_outlach = (r_state == ST_ALU_EX);
  assign cu.ALU_outEN   = (r_state == ST_ALU_WB);

  assign cu.G0_out = w_src_vec[SEL_G0];
  assign cu.G1_out = w_src_vec[SEL_G1];
  assign cu.G2_out = w_src_vec[SEL_G2];
  assign cu.G3_out = w_src_vec[SEL_G3];
  assign cu.P0_out = w_src_vec[SEL_P0];
  assign cu.P1_out = w_src_vec[SEL_P1];
  assign cu.PC_EN  = w_src_vec[SEL_PC];

  assign cu.G0_in = w_dst_vec[SEL_G0];
  assign cu.G1_in = w_dst_vec[SEL_G1];
  assign cu.G2_in = w_dst_vec[SEL_G2];
  assign cu.G3_in = w_dst_vec[SEL_G3];
  assign cu.P0_in = w_dst_vec[SEL_P0];
  assign cu.P1_in = (r_state == ST_IN);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with a small bus/register model of the datapath.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_unit_if if0();
  mc_control_unit_if if1();

  mc_control_unit #(.HALT_ON_ERR(1'b0)) u_dut0 (.clk(clk), .rst(rst), .cu(if0.slave));
  mc_control_unit #(.HALT_ON_ERR(1'b1)) u_dut1 (.clk(clk), .rst(rst), .cu(if1.slave));

  int n_vec = 0;
  int n_err = 0;

  // Strobe vector bit positions
  localparam logic [22:0] S_P1_OUT  = 23'(1) << 0;
  localparam logic [22:0] S_P1_IN   = 23'(1) << 1;
  localparam logic [22:0] S_P0_OUT  = 23'(1) << 2;
  localparam logic [22:0] S_P0_IN   = 23'(1) << 3;
  localparam logic [22:0] S_PC_EN   = 23'(1) << 4;
  localparam logic [22:0] S_G3_OUT  = 23'(1) << 5;
  localparam logic [22:0] S_G2_OUT  = 23'(1) << 6;
  localparam logic [22:0] S_G1_OUT  = 23'(1) << 7;
  localparam logic [22:0] S_G0_OUT  = 23'(1) << 8;
  localparam logic [22:0] S_G3_IN   = 23'(1) << 9;
  localparam logic [22:0] S_G2_IN   = 23'(1) << 10;
  localparam logic [22:0] S_G1_IN   = 23'(1) << 11;
  localparam logic [22:0] S_G0_IN   = 23'(1) << 12;
  localparam logic [22:0] S_OUTEN   = 23'(1) << 13;
  localparam logic [22:0] S_OUTLACH = 23'(1) << 14;
  localparam logic [22:0] S_ALUIN2  = 23'(1) << 15;
  localparam logic [22:0] S_ALUIN1  = 23'(1) << 16;
  localparam logic [22:0] S_OP1     = 23'(1) << 17;
  localparam logic [22:0] S_ERR     = 23'(1) << 20;
  localparam logic [22:0] S_DONE    = 23'(1) << 21;
  localparam logic [22:0] S_RDY     = 23'(1) << 22;
  localparam logic [22:0] DRV_MASK  = S_P1_OUT | S_P0_OUT | S_PC_EN | S_G3_OUT | S_G2_OUT |
                                      S_G1_OUT | S_G0_OUT | S_OUTEN;
  localparam logic [15:0] PC_VAL    = 16'h0100;

  logic [22:0] obs0, obs1;
  assign obs0 = {if0.instr_ready, if0.done, if0.err, if0.opCode, if0.ALUin1, if0.ALUin2,
                 if0.ALU_outlach, if0.ALU_outEN, if0.G0_in, if0.G1_in, if0.G2_in, if0.G3_in,
                 if0.G0_out, if0.G1_out, if0.G2_out, if0.G3_out, if0.PC_EN,
                 if0.P0_in, if0.P0_out, if0.P1_in, if0.P1_out};
  assign obs1 = {if1.instr_ready, if1.done, if1.err, if1.opCode, if1.ALUin1, if1.ALUin2,
                 if1.ALU_outlach, if1.ALU_outEN, if1.G0_in, if1.G1_in, if1.G2_in, if1.G3_in,
                 if1.G0_out, if1.G1_out, if1.G2_out, if1.G3_out, if1.PC_EN,
                 if1.P0_in, if1.P0_out, if1.P1_in, if1.P1_out};

  // Datapath model: registers load from the shared bus at the edge ending a strobe
  logic [15:0] g [4];
  logic [15:0] p0, p1, alu_a, alu_b, alu_r, bus, p1_pins;
  logic        load_en;
  int          load_sel;
  logic [15:0] load_val;

  function automatic logic [15:0] alu_fn(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a & b;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    if (if0.G0_out)    bus = g[0];
    if (if0.G1_out)    bus = g[1];
    if (if0.G2_out)    bus = g[2];
    if (if0.G3_out)    bus = g[3];
    if (if0.P0_out)    bus = p0;
    if (if0.P1_out)    bus = p1;
    if (if0.PC_EN)     bus = PC_VAL;
    if (if0.ALU_outEN) bus = alu_r;
  end

  always @(posedge clk) begin
    if (load_en)         g[load_sel] <= load_val;
    if (if0.ALUin1)      alu_a <= bus;
    if (if0.ALUin2)      alu_b <= bus;
    if (if0.ALU_outlach) alu_r <= alu_fn(if0.opCode, alu_a, alu_b);
    if (if0.G0_in)       g[0] <= bus;
    if (if0.G1_in)       g[1] <= bus;
    if (if0.G2_in)       g[2] <= bus;
    if (if0.G3_in)       g[3] <= bus;
    if (if0.P0_in)       p0 <= bus;
    if (if0.P1_in)       p1 <= p1_pins;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // At most one bus driver per cycle on either instance
  always @(negedge clk) begin
    if (!rst) begin
      check("one_driver_dut0", 32'($countones(obs0 & DRV_MASK) <= 1), 32'd1);
      check("one_driver_dut1", 32'($countones(obs1 & DRV_MASK) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preset(input int sel, input logic [15:0] val);
    load_en  = 1'b1;
    load_sel = sel;
    load_val = val;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic issue0(input logic [15:0] w);
    if0.instr       = w;
    if0.instr_valid = 1'b1;
    tick();
    if0.instr_valid = 1'b0;
  endtask

  initial begin
    if0.instr = '0; if0.instr_valid = 1'b0;
    if1.instr = '0; if1.instr_valid = 1'b0;
    load_en = 1'b0; load_sel = 0; load_val = '0; p1_pins = '0;

    tick(); tick();
    check("reset_dut0", 32'(obs0), 32'(S_RDY));
    check("reset_dut1", 32'(obs1), 32'(S_RDY));
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'(obs0), 32'(S_RDY));

    // MOV G2 <- G0
    preset(0, 16'h1234);
    issue0(16'h0200);
    check("mov_strobes", 32'(obs0), 32'(S_G0_OUT | S_G2_IN | S_DONE));
    tick();
    check("mov_ready", 32'(obs0), 32'(S_RDY));
    check("mov_g2", 32'(g[2]), 32'h1234);

    // ALU op 001: G3 <- G1 - G2
    preset(1, 16'h0005);
    preset(2, 16'h0003);
    issue0(16'h4B28);
    check("alu_a", 32'(obs0), 32'(S_G1_OUT | S_ALUIN1));
    tick();
    check("alu_b", 32'(obs0), 32'(S_G2_OUT | S_ALUIN2));
    tick();
    check("alu_ex", 32'(obs0), 32'(S_OUTLACH | S_OP1));
    tick();
    check("alu_wb", 32'(obs0), 32'(S_OUTEN | S_G3_IN | S_DONE));
    tick();
    check("alu_ready", 32'(obs0), 32'(S_RDY));
    check("alu_g3", 32'(g[3]), 32'h0002);

    // ALU op 000 with srcA == srcB == G1, dst P0
    issue0(16'h4424);
    check("alu2_a", 32'(obs0), 32'(S_G1_OUT | S_ALUIN1));
    tick();
    check("alu2_b", 32'(obs0), 32'(S_G1_OUT | S_ALUIN2));
    tick();
    check("alu2_ex", 32'(obs0), 32'(S_OUTLACH));
    tick();
    check("alu2_wb", 32'(obs0), 32'(S_OUTEN | S_P0_IN | S_DONE));
    tick();
    check("alu2_p0", 32'(p0), 32'h000A);

    // MOV G0 <- PC
    issue0(16'h00C0);
    check("mov_pc_strobes", 32'(obs0), 32'(S_PC_EN | S_G0_IN | S_DONE));
    tick();
    check("mov_pc_g0", 32'(g[0]), 32'(PC_VAL));

    // IN samples the pins into P1
    p1_pins = 16'hBEEF;
    issue0(16'h8000);
    check("in_strobes", 32'(obs0), 32'(S_P1_IN | S_DONE));
    tick();
    check("in_p1", 32'(p1), 32'hBEEF);
    check("in_ready", 32'(obs0), 32'(S_RDY));

    // NOP with every field set: no legality check, done only
    issue0(16'hFFFF);
    check("nop_strobes", 32'(obs0), 32'(S_DONE));
    tick();
    check("nop_ready", 32'(obs0), 32'(S_RDY));

    // Illegal MOV dst=PC, and ALU with srcB=7, both return to IDLE
    issue0(16'h0600);
    check("err_mov", 32'(obs0), 32'(S_DONE | S_ERR));
    tick();
    check("err_mov_idle", 32'(obs0), 32'(S_RDY));
    issue0(16'h401C);
    check("err_alu", 32'(obs0), 32'(S_DONE | S_ERR));
    tick();
    check("err_alu_idle", 32'(obs0), 32'(S_RDY));

    // Halting instance parks in HALT and ignores further valid words
    if1.instr = 16'h0600; if1.instr_valid = 1'b1;
    tick();
    check("halt_err", 32'(obs1), 32'(S_DONE | S_ERR));
    if1.instr = 16'h0000;
    tick();
    check("halt_parked", 32'(obs1), 32'd0);
    tick();
    check("halt_stays", 32'(obs1), 32'd0);
    if1.instr_valid = 1'b0;

    // Reset during ALU_B abandons the transfer
    preset(1, 16'h0007);
    issue0(16'h4B28);
    tick();
    check("rst_pre_alu_b", 32'(obs0), 32'(S_G2_OUT | S_ALUIN2));
    #1 rst = 1'b1;
    #1 check("rst_async_clear", 32'(obs0), 32'(S_RDY));
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_idle_dut0", 32'(obs0), 32'(S_RDY));
    check("rst_idle_dut1", 32'(obs1), 32'(S_RDY));
    check("rst_g3_kept", 32'(g[3]), 32'h0002);

    // Back-to-back with instr_valid held: second word waits for the IDLE edge
    if0.instr = 16'h0200; if0.instr_valid = 1'b1;
    tick();
    check("b2b_mov", 32'(obs0), 32'(S_G0_OUT | S_G2_IN | S_DONE));
    if0.instr = 16'h4B28;
    tick();
    check("b2b_idle", 32'(obs0), 32'(S_RDY));
    tick();
    if0.instr_valid = 1'b0;
    check("b2b_alu_a", 32'(obs0), 32'(S_G1_OUT | S_ALUIN1));
    tick(); tick(); tick();
    check("b2b_alu_wb", 32'(obs0), 32'(S_OUTEN | S_G3_IN | S_DONE));
    tick();
    check("b2b_g3", 32'(g[3]), 32'hFF07);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Instruction sequencer for the 16-bit bus microcontroller datapath. It accepts one instruction word at a time over a valid/ready handshake and decodes it. It then steps through a multi-cycle state machine that drives every datapath control strobe: ALU input latches, ALU output latch and enable, G0–G3 in/out, PC_EN, and P0/P1 in/out. It sits between the instruction source (testbench now, fetch unit later) and the datapath top level, replacing hand-driven strobes.

## Interface
- HALT_ON_ERR, 0, when 1 an illegal instruction parks the FSM in HALT until reset; when 0 the FSM returns to IDLE.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  16  instruction word: [15:14] type, [13:11] ALU op, [10:8] dst sel, [7:5] srcA sel, [4:2] srcB sel, [1:0] reserved (ignored).
- instr_valid  in  1  instruction present.
- instr_ready  out  1  high only in IDLE.
- done  out  1  high for the final cycle of every instruction, including error and NOP.
- err  out  1  high with done for illegal selectors.
- opCode  out  3  ALU operation, IR op in ALU_EX, else 000.
- ALUin1, ALUin2, ALU_outlach, ALU_outEN  out  1 each  ALU strobes.
- G0_in..G3_in, G0_out..G3_out  out  1 each  general register strobes.
- PC_EN  out  1  program counter bus drive.
- P0_in, P0_out, P1_in, P1_out  out  1 each  port strobes.

## Operation
- Types: 00 MOV dst←srcA; 01 ALU dst←srcA op srcB; 10 IN: P1 samples external pins; 11 NOP.
- Source selector: 0–3 G0–G3, 4 P0, 5 P1, 6 PC, 7 illegal.
- Dest selector: 0–3 G0–G3, 4 P0; 5, 6, 7 illegal. P1 loads only from pins and PC is not writable.
- Legality is checked only for fields the type uses: MOV checks dst and srcA; ALU checks dst, srcA and srcB; IN and NOP check nothing.
- Accept: on a rising edge with instr_valid && instr_ready, instr is latched into the IR and the FSM leaves IDLE.
- States and transitions:
  - IDLE → MOV, ALU_A, IN, NOP or ERR.
  - MOV: srcA *_out=1 and dst *_in=1, done=1 → IDLE.
  - ALU_A: srcA *_out=1, ALUin1=1 → ALU_B.
  - ALU_B: srcB *_out=1, ALUin2=1 → ALU_EX.
  - ALU_EX: opCode=IR op, ALU_outlach=1 → ALU_WB.
  - ALU_WB: ALU_outEN=1, dst *_in=1, done=1 → IDLE.
  - IN: P1_in=1, done=1 → IDLE.
  - NOP: done=1 → IDLE.
  - ERR: done=1, err=1, no strobes → IDLE, or HALT when HALT_ON_ERR=1.
  - HALT: all outputs 0 including instr_ready; exit only by reset.
- Outputs are decoded from the state register and IR only, with no combinational path from instr or instr_valid.
- Invariant: at most one bus driver (any *_out, ALU_outEN, PC_EN) is high in any cycle.
- srcA == dst is legal. srcA == srcB is legal; the same register is read twice.
- instr is ignored whenever instr_ready=0. instr_valid held high with a new word is accepted only on the next IDLE edge.

## Timing
- Latency from the accept edge to done: MOV, IN, NOP and ERR 1 cycle; ALU 4 cycles.
- After done there is one IDLE cycle before the next accept. Throughput: MOV 2 cycles per instruction, ALU 5 cycles per instruction.
- Bus transfers complete at the rising edge that ends the state asserting the strobes. This relies on the datapath's bus_out-to-bus_in loop.
- Reset values: state IDLE, IR 0, instr_ready 1, all other outputs 0.
- Reset asserted mid-instruction clears all strobes immediately (asynchronously). The partial transfer is abandoned and no done is produced.
- Deassertion of rst is synchronized by the system; the FSM leaves IDLE no earlier than the first edge after release.

## Structure
- Shared package mc_ctrl_pkg holds:
  - type codes TYPE_MOV/ALU/IN/NOP;
  - selector codes SEL_G0..SEL_PC and SEL_ILLEGAL;
  - the FSM state enum;
  - instruction field bit positions.
- One sub-module, mc_sel_decode: a combinational 3-bit selector to one-hot out/in enable vector. It is instantiated twice, once for the source and once for the destination.

## Test plan
- Reset, then 0x0200 (MOV G2←G0) with G0=0x1234 → 1 cycle later G0_out=G2_in=done=1 → G2=0x1234 → instr_ready=1 two cycles after accept.
- 0x4B28 (ALU op 001, G3←G1 op G2), G1=0x0005, G2=0x0003 → ALUin1, ALUin2, ALU_outlach (opCode=001), ALU_outEN+G3_in on four consecutive cycles → done on cycle 4 → G3 holds the ALU result.
- 0x8000 (IN) with P1 pins=0xBEEF → P1_in=1 for one cycle, done=1 → P1=0xBEEF. Then 0xC000 (NOP) → done only, no strobes.
- 0x0600 (MOV dst=PC, illegal) with HALT_ON_ERR=0 → done=err=1 for one cycle → IDLE. With HALT_ON_ERR=1 → HALT, instr_ready stays 0 until rst.
- rst asserted during ALU_B of 0x4B28 → all strobes 0 in the same cycle, G3 unchanged, state IDLE, instr_ready=1 after release.
- Back-to-back: instr_valid held high across 0x0200 then 0x4B28 → second word accepted only on the IDLE edge. Single-driver invariant is checked by assertion every cycle.
